// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring integer divider, one quotient bit per clock.
// Signed or unsigned per operation; flags divide-by-zero and MIN/-1 overflow.
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ZERO_W   = '0;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_work;
    logic [WIDTH-1:0] dsr_mag;
    logic [WIDTH:0]   r_work;
    logic             neg_q, neg_r, dz_pend, ov_pend;

    logic             dvd_neg, dsr_neg, is_zero, is_ovf, q_bit;
    logic [WIDTH-1:0] dvd_abs, dsr_abs, q_next;
    logic [WIDTH:0]   r_shift, r_diff, r_next;

    // Negating MIN in WIDTH bits yields the correct unsigned magnitude 2^(WIDTH-1).
    always_comb begin
        dvd_neg = signed_mode & dividend[WIDTH-1];
        dsr_neg = signed_mode & divisor[WIDTH-1];
        dvd_abs = dvd_neg ? (ZERO_W - dividend) : dividend;
        dsr_abs = dsr_neg ? (ZERO_W - divisor) : divisor;
        is_zero = (divisor == '0);
        is_ovf  = signed_mode && (dividend == MIN_VAL) && (divisor == '1);
    end

    // q_work doubles as the dividend shift register; quotient bits enter at the LSB.
    always_comb begin
        r_shift = (r_work << 1) | {{WIDTH{1'b0}}, q_work[WIDTH-1]};
        r_diff  = r_shift - {1'b0, dsr_mag};
        q_bit   = (r_shift >= {1'b0, dsr_mag});
        r_next  = q_bit ? r_diff : r_shift;
        q_next  = {q_work[WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            cnt         <= '0;
            q_work      <= '0;
            r_work      <= '0;
            dsr_mag     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz_pend     <= 1'b0;
            ov_pend     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        cnt         <= '0;
                        dsr_mag     <= dsr_abs;
                        if (is_zero) begin
                            q_work  <= '1;
                            r_work  <= {1'b0, dividend};
                            neg_q   <= 1'b0;
                            neg_r   <= 1'b0;
                            dz_pend <= 1'b1;
                            ov_pend <= 1'b0;
                            state   <= StFix;
                        end else if (is_ovf) begin
                            q_work  <= MIN_VAL;
                            r_work  <= '0;
                            neg_q   <= 1'b0;
                            neg_r   <= 1'b0;
                            dz_pend <= 1'b0;
                            ov_pend <= 1'b1;
                            state   <= StFix;
                        end else begin
                            q_work  <= dvd_abs;
                            r_work  <= '0;
                            neg_q   <= dvd_neg ^ dsr_neg;
                            neg_r   <= dvd_neg;
                            dz_pend <= 1'b0;
                            ov_pend <= 1'b0;
                            state   <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    q_work <= q_next;
                    r_work <= r_next;
                    cnt    <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state <= StFix;
                    end
                end
                StFix: begin
                    quotient    <= neg_q ? (ZERO_W - q_work) : q_work;
                    remainder   <= neg_r ? (ZERO_W - r_work[WIDTH-1:0]) : r_work[WIDTH-1:0];
                    div_by_zero <= dz_pend;
                    overflow    <= ov_pend;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: 8-bit hand-computed vectors plus a 16-bit
// sweep checked against the language's own truncating division.
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0, sm = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic        busy8, done8, dz8, ov8;
    logic [7:0]  q8, r8;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, dz16, ov16;
    logic [15:0] q16, r16;

    int n_pass   = 0;
    int n_checks = 0;

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
        .dividend(a), .divisor(b), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(dz8), .overflow(ov8)
    );

    seq_divider #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .dividend(a16), .divisor(b16), .busy(busy16), .done(done16),
        .quotient(q16), .remainder(r16), .div_by_zero(dz16), .overflow(ov16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // poke >= 0 re-pulses start with other operands that many cycles after accept.
    task automatic op8(input string tag, input logic smv, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] eq, input logic [7:0] er, input logic edz, input logic eov,
                       input int elat, input int poke);
        int   n;
        logic busy_ok;
        @(negedge clk);
        start = 1'b1; sm = smv; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = ~av; b = 8'h00;
        check({tag, " busy@accept"}, busy8, 1'b1);
        check({tag, " flags@accept"}, {dz8, ov8}, 2'b00);
        n = 0;
        busy_ok = 1'b1;
        while (!done8 && n < 40) begin
            if (n == poke) begin
                start = 1'b1; a = 8'd9; b = 8'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (!done8 && !busy8) busy_ok = 1'b0;
        end
        start = 1'b0;
        check({tag, " latency"}, n, elat);
        check({tag, " busy held"}, busy_ok, 1'b1);
        check({tag, " busy@done"}, busy8, 1'b0);
        check({tag, " q"}, q8, eq);
        check({tag, " r"}, r8, er);
        check({tag, " dz/ov"}, {dz8, ov8}, {edz, eov});
        @(posedge clk); #1;
        check({tag, " done pulse"}, done8, 1'b0);
    endtask

    task automatic ref16(input logic smv, input logic [15:0] av, input logic [15:0] bv,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic [1:0] fl, output int lat);
        if (bv == 16'h0000) begin
            q = 16'hFFFF; r = av; fl = 2'b10; lat = 1;
        end else if (smv && av == 16'h8000 && bv == 16'hFFFF) begin
            q = 16'h8000; r = 16'h0000; fl = 2'b01; lat = 1;
        end else if (smv) begin
            q = $signed(av) / $signed(bv); r = $signed(av) % $signed(bv); fl = 2'b00; lat = 17;
        end else begin
            q = av / bv; r = av % bv; fl = 2'b00; lat = 17;
        end
    endtask

    task automatic op16(input string tag, input logic smv, input logic [15:0] av, input logic [15:0] bv);
        logic [15:0] eq, er;
        logic [1:0]  efl;
        int          elat, n;
        ref16(smv, av, bv, eq, er, efl, elat);
        @(negedge clk);
        start16 = 1'b1; sm16 = smv; a16 = av; b16 = bv;
        @(posedge clk); #1;
        start16 = 1'b0; a16 = ~av; b16 = 16'h0;
        n = 0;
        while (!done16 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, n, elat);
        check({tag, " q"}, q16, eq);
        check({tag, " r"}, r16, er);
        check({tag, " dz/ov"}, {dz16, ov16}, efl);
    endtask

    initial begin
        logic saw_done;
        logic [15:0] ra, rb;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy8, 1'b0);
        check("reset done", done8, 1'b0);
        check("reset q", q8, 8'h00);
        check("reset r", r8, 8'h00);
        check("reset flags", {dz8, ov8}, 2'b00);
        rst = 1'b0;

        op8("u 100/7",     1'b0, 8'd100, 8'd7,  8'd14,  8'd2,  1'b0, 1'b0, 9, -1);
        op8("s -100/7",    1'b1, 8'h9C,  8'h07, 8'hF2,  8'hFE, 1'b0, 1'b0, 9, -1);
        op8("s 100/-7",    1'b1, 8'h64,  8'hF9, 8'hF2,  8'h02, 1'b0, 1'b0, 9, -1);
        op8("u 55/0",      1'b0, 8'd55,  8'd0,  8'hFF,  8'd55, 1'b1, 1'b0, 1, -1);
        op8("s 55/0",      1'b1, 8'd55,  8'd0,  8'hFF,  8'd55, 1'b1, 1'b0, 1, -1);
        op8("s -100/0",    1'b1, 8'h9C,  8'h00, 8'hFF,  8'h9C, 1'b1, 1'b0, 1, -1);
        op8("u 100/7 clr", 1'b0, 8'd100, 8'd7,  8'd14,  8'd2,  1'b0, 1'b0, 9, -1);
        op8("s MIN/-1",    1'b1, 8'h80,  8'hFF, 8'h80,  8'h00, 1'b0, 1'b1, 1, -1);
        op8("u 128/255",   1'b0, 8'h80,  8'hFF, 8'h00,  8'h80, 1'b0, 1'b0, 9, -1);
        op8("s MIN/7",     1'b1, 8'h80,  8'h07, 8'hEE,  8'hFE, 1'b0, 1'b0, 9, -1);
        op8("s -127/MIN",  1'b1, 8'h81,  8'h80, 8'h00,  8'h81, 1'b0, 1'b0, 9, -1);
        op8("s MIN/MIN",   1'b1, 8'h80,  8'h80, 8'h01,  8'h00, 1'b0, 1'b0, 9, -1);
        op8("u 255/1",     1'b0, 8'hFF,  8'h01, 8'hFF,  8'h00, 1'b0, 1'b0, 9, -1);
        op8("u 200/3 poke", 1'b0, 8'd200, 8'd3, 8'd66,  8'd2,  1'b0, 1'b0, 9, 3);

        // Abort in the middle of CALC; previous result (66, 2) must be wiped.
        @(negedge clk);
        start = 1'b1; sm = 1'b0; a = 8'd100; b = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", busy8, 1'b0);
        check("abort q", q8, 8'h00);
        check("abort r", r8, 8'h00);
        saw_done = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done8) saw_done = 1'b1;
        end
        check("abort no done", saw_done, 1'b0);
        op8("u 77/5 after rst", 1'b0, 8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 1'b0, 9, -1);

        op16("w16 s MIN/1",    1'b1, 16'h8000, 16'h0001);
        op16("w16 s MAX/-1",   1'b1, 16'h7FFF, 16'hFFFF);
        op16("w16 s MIN/-1",   1'b1, 16'h8000, 16'hFFFF);
        op16("w16 u MIN/-1",   1'b0, 16'h8000, 16'hFFFF);
        op16("w16 u 0/5",      1'b0, 16'h0000, 16'h0005);
        op16("w16 u FFFF/1",   1'b0, 16'hFFFF, 16'h0001);
        op16("w16 s x/0",      1'b1, 16'h1234, 16'h0000);
        op16("w16 s MIN/MAX",  1'b1, 16'h8000, 16'h7FFF);
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            op16($sformatf("w16 rnd%0d", i), 1'($urandom_range(0, 1)), ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
